// File: rtl/spi_sub.sv
// SPI subordinate for the AES block link: oversampled full-duplex FRAME_BITS-bit transfer.
// Received frames are presented on rx with a one-cycle rx_valid pulse.
module spi_sub #(
  parameter int unsigned FRAME_BITS = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  input  logic [0:FRAME_BITS-1] tx,
  output logic                  miso,
  output logic [0:FRAME_BITS-1] rx,
  output logic                  rx_valid,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int unsigned CntW = $clog2(FRAME_BITS + 1);
  localparam int unsigned IdxW = $clog2(FRAME_BITS);
  localparam logic [CntW-1:0] Full = CntW'(FRAME_BITS);
  localparam logic [CntW-1:0] Last = CntW'(FRAME_BITS - 1);

  typedef enum logic [1:0] {StIdle, StShift, StHold} state_e;

  // [0],[1] synchronize; [2] is the edge-detect register
  logic [2:0] sclk_sync;
  logic [2:0] cs_sync;
  logic [1:0] mosi_sync;

  state_e                state_q, state_d;
  logic [0:FRAME_BITS-1] tx_q, tx_d;
  logic [0:FRAME_BITS-1] sh_q, sh_d;
  logic [0:FRAME_BITS-1] rx_q, rx_d;
  logic [CntW-1:0]       tcnt_q, tcnt_d;
  logic [CntW-1:0]       rcnt_q, rcnt_d;
  logic                  miso_q, miso_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  frame_err_q, frame_err_d;
  logic                  busy_q, busy_d;

  logic sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_s;

  assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
  assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
  assign cs_fall   = ~cs_sync[1] & cs_sync[2];
  assign cs_rise   = cs_sync[1] & ~cs_sync[2];
  assign mosi_s    = mosi_sync[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync   <= 3'b000;
      cs_sync     <= 3'b111;
      mosi_sync   <= 2'b00;
      state_q     <= StIdle;
      tx_q        <= '0;
      sh_q        <= '0;
      rx_q        <= '0;
      tcnt_q      <= '0;
      rcnt_q      <= '0;
      miso_q      <= 1'b0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sclk_sync   <= {sclk_sync[1:0], sclk};
      cs_sync     <= {cs_sync[1:0], cs_n};
      mosi_sync   <= {mosi_sync[0], mosi};
      state_q     <= state_d;
      tx_q        <= tx_d;
      sh_q        <= sh_d;
      rx_q        <= rx_d;
      tcnt_q      <= tcnt_d;
      rcnt_q      <= rcnt_d;
      miso_q      <= miso_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tx_d        = tx_q;
    sh_d        = sh_q;
    rx_d        = rx_q;
    tcnt_d      = tcnt_q;
    rcnt_d      = rcnt_q;
    miso_d      = miso_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    busy_d      = busy_q;
    unique case (state_q)
      StIdle: begin
        miso_d = 1'b0;
        busy_d = 1'b0;
        if (cs_fall) begin
          tx_d    = tx;
          tcnt_d  = '0;
          rcnt_d  = '0;
          miso_d  = tx[0];
          busy_d  = 1'b1;
          state_d = StShift;
        end
      end
      StShift: begin
        if (rcnt_q == Full) begin
          rx_d       = sh_q;
          rx_valid_d = 1'b1;
          // cs_n may already be high if it rose together with the final sclk fall
          if (cs_sync[1]) begin
            busy_d  = 1'b0;
            miso_d  = 1'b0;
            state_d = StIdle;
          end else begin
            state_d = StHold;
          end
        end else begin
          if (sclk_fall) begin
            sh_d   = {sh_q[1:FRAME_BITS-1], mosi_s};
            rcnt_d = rcnt_q + CntW'(1);
          end else if (sclk_rise && tcnt_q < Full) begin
            miso_d = tx_q[tcnt_q[IdxW-1:0]];
            tcnt_d = tcnt_q + CntW'(1);
          end
          // A cs_n rise coinciding with the final bit lets the frame complete
          if (cs_rise && !(sclk_fall && rcnt_q == Last)) begin
            frame_err_d = 1'b1;
            busy_d      = 1'b0;
            miso_d      = 1'b0;
            state_d     = StIdle;
          end
        end
      end
      StHold: begin
        if (cs_sync[1]) begin
          busy_d  = 1'b0;
          miso_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign miso      = miso_q;
  assign rx        = rx_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_spi_sub.sv
// Bench for spi_sub: a bit-banged SPI main with a frame-level model of expected rx words,
// frame errors and returned miso words; a per-cycle monitor compares the DUT against it.
module tb_spi_sub;

  logic         clk, rst, sclk, cs_n, mosi;
  logic [0:127] tx;
  logic         miso;
  logic [0:127] rx;
  logic         rx_valid, frame_err, busy;

  int checks   = 0;
  int failures = 0;

  logic [0:127] model_rx;
  logic [0:127] exp_q[$];
  int           exp_err = 0;

  spi_sub #(.FRAME_BITS(128)) dut (
    .clk      (clk),
    .rst      (rst),
    .sclk     (sclk),
    .cs_n     (cs_n),
    .mosi     (mosi),
    .tx       (tx),
    .miso     (miso),
    .rx       (rx),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Per-cycle monitor: rx only changes with rx_valid, pulses match the model's expectations.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rx_valid", 128'(rx_valid), 128'd0);
        end else begin
          chk("rx_data", rx, exp_q[0]);
          model_rx = exp_q.pop_front();
        end
      end else begin
        chk("rx_stable", rx, model_rx);
      end
      if (frame_err) begin
        if (exp_err == 0) chk("unexpected_frame_err", 128'(frame_err), 128'd0);
        else exp_err--;
      end
      if (!busy) chk("miso_idle", 128'(miso), 128'd0);
    end
  end

  // One frame from the main. rst_at >= 0 resets mid-frame before that bit;
  // simul raises cs_n together with the last sclk fall.
  task automatic do_frame(input logic [0:127] m, input logic [0:127] t, input logic [0:127] t_mid,
                          input int half, input int nbits, input int rst_at, input bit simul,
                          output logic [0:127] cap);
    cap = '0;
    tx  = t;
    if (rst_at < 0) begin
      if (nbits == 128) exp_q.push_back(m);
      else exp_err++;
    end
    cs_n = 1'b0;
    wait_clk(5);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        rst      = 1'b1;
        cs_n     = 1'b1;
        sclk     = 1'b0;
        model_rx = '0;
        #1;
        chk("rst_outputs", {miso, rx_valid, frame_err, busy}, 128'd0);
        chk("rst_rx", rx, 128'd0);
        wait_clk(3);
        rst = 1'b0;
        wait_clk(5);
        return;
      end
      if (i == 64) tx = t_mid;
      sclk = 1'b1;
      mosi = m[i];
      wait_clk(half);
      cap[i] = miso;
      if (simul && i == nbits - 1) cs_n = 1'b1;
      sclk = 1'b0;
      wait_clk(half);
    end
    if (!simul) begin
      wait_clk(5);
      cs_n = 1'b1;
      wait_clk(2);
      chk("busy_hold", 128'(busy), 128'd1);
      wait_clk(1);
      chk("busy_fall", 128'(busy), 128'd0);
    end else begin
      wait_clk(6);
      chk("busy_simul", 128'(busy), 128'd0);
    end
    wait_clk(6);
  endtask

  logic [0:127] cap, m, t;
  int           half, nb;

  initial begin
    rst      = 1'b1;
    sclk     = 1'b0;
    cs_n     = 1'b1;
    mosi     = 1'b0;
    tx       = '0;
    model_rx = '0;
    #1;
    chk("reset_outputs", {miso, rx_valid, frame_err, busy}, 128'd0);
    chk("reset_rx", rx, 128'd0);
    wait_clk(3);
    rst = 1'b0;
    wait_clk(4);

    // Full frame, sclk period 10
    do_frame(128'h00112233445566778899AABBCCDDEEFF, 128'h0123456789ABCDEF_FEDCBA9876543210,
             128'h0123456789ABCDEF_FEDCBA9876543210, 5, 128, -1, 1'b0, cap);
    chk("f1_rx_literal", rx, 128'h00112233445566778899AABBCCDDEEFF);
    chk("f1_miso_literal", cap, 128'h0123456789ABCDEF_FEDCBA9876543210);

    // Back-to-back with tx changing between frames
    do_frame({16{8'hA5}}, '1, '1, 5, 128, -1, 1'b0, cap);
    chk("b2b1_miso", cap, '1);
    chk("b2b1_rx", rx, {16{8'hA5}});
    do_frame({16{8'h5A}}, '0, '0, 5, 128, -1, 1'b0, cap);
    chk("b2b2_miso", cap, '0);
    chk("b2b2_rx", rx, {16{8'h5A}});

    // Abort after 37 bits: rx keeps previous value, next frame is fine
    do_frame(128'hFFFF_0000_1234_5678_9ABC_DEF0_1111_2222, '0, '0, 5, 37, -1, 1'b0, cap);
    chk("abort_rx_kept", rx, {16{8'h5A}});
    chk("abort_err_seen", 128'(exp_err), 128'd0);
    do_frame(128'h0F0F_F0F0_3C3C_C3C3_1234_5678_9ABC_DEF0, 128'h55, 128'h55, 5, 128, -1, 1'b0, cap);
    chk("after_abort_miso", cap, 128'h55);

    // tx change mid-frame has no effect on the current frame
    do_frame(128'hCAFE, '0, '1, 5, 128, -1, 1'b0, cap);
    chk("tx_mid_miso", cap, '0);

    // Reset at bit 100, then a clean frame
    do_frame(128'h1, 128'h2, 128'h2, 5, 128, 100, 1'b0, cap);
    do_frame(128'h7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE, 128'h3, 128'h3, 5, 128, -1, 1'b0, cap);
    chk("after_rst_rx", rx, 128'h7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE);
    chk("after_rst_miso", cap, 128'h3);

    // cs_n rising with the last sclk fall still completes the frame
    do_frame(128'hABCD_0123, 128'h9, 128'h9, 5, 128, -1, 1'b1, cap);

    // sclk noise with cs_n high
    for (int i = 0; i < 200; i++) begin
      sclk = ~sclk;
      mosi = 1'($urandom);
      wait_clk(2);
    end
    sclk = 1'b0;
    wait_clk(4);
    chk("noise_busy", 128'(busy), 128'd0);
    chk("noise_rx", rx, 128'hABCD_0123);

    // Minimum half-period
    do_frame(128'hDEADBEEF_CAFEBABE_0F1E2D3C_4B5A6978, 128'hDEADBEEF_CAFEBABE_0F1E2D3C_4B5A6978,
             128'hDEADBEEF_CAFEBABE_0F1E2D3C_4B5A6978, 4, 128, -1, 1'b0, cap);
    chk("fast_miso", cap, 128'hDEADBEEF_CAFEBABE_0F1E2D3C_4B5A6978);
    chk("fast_rx", rx, 128'hDEADBEEF_CAFEBABE_0F1E2D3C_4B5A6978);

    // Randomized frames, some aborted
    for (int r = 0; r < 6; r++) begin
      m    = {$urandom, $urandom, $urandom, $urandom};
      t    = {$urandom, $urandom, $urandom, $urandom};
      half = $urandom_range(4, 7);
      nb   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 127) : 128;
      do_frame(m, t, t, half, nb, -1, 1'b0, cap);
      if (nb == 128) chk("rand_miso", cap, t);
    end

    wait_clk(4);
    chk("pending_rx_valid", 128'(exp_q.size()), 128'd0);
    chk("pending_frame_err", 128'(exp_err), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
